simple_serial_tx: RTL and testbench
===================================

SIMPLE_SERIAL_TX -- requirements
Module: simple_serial_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: bits per serial word.
REQ-002 SHALL have parameter CLK_DIV, default 4: sclk half-period in aclk cycles; legal range >=1.
REQ-003 SHALL have parameter WORD_GAP, default 2: idle sclk periods after a non-last word; legal range >=1.
REQ-004 SHALL have parameter PKT_GAP, default 8: idle sclk periods after a tlast word; legal range >=1.
REQ-005 SHALL have port aclk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port areset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port s_axis_tdata, input, DATA_WIDTH: the word to send.
REQ-008 SHALL have ports s_axis_tvalid (input, 1), s_axis_tready (output, 1) and s_axis_tlast (input, 1): the AXI-Stream handshake and end-of-packet flag.
REQ-009 SHALL have port sclk, output, 1: the free-running serial clock; the receiver samples on its rising edge.
REQ-010 SHALL have ports sdata (output, 1) and svalid (output, 1): serial data, MSB first, and the word-framing strobe.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-012 SHALL toggle sclk every CLK_DIV aclk cycles (period 2*CLK_DIV), starting low after reset; a one-cycle internal fall_tick marks each 1->0 transition.
REQ-013 SHALL update sdata and svalid only in the aclk cycle of fall_tick, from registers; both stay stable for a full sclk period.
REQ-014 SHALL implement FSM IDLE -> WAIT -> SHIFT -> [PARITY] -> GAP -> IDLE.
REQ-015 SHALL drive s_axis_tready high only in IDLE; a handshake (tvalid & tready) latches tdata and tlast and enters WAIT on the next cycle.
REQ-016 SHALL, in WAIT, load the MSB onto sdata and raise svalid at the next fall_tick, then enter SHIFT; handshake-to-svalid latency is at most 2*CLK_DIV+1 aclk cycles.
REQ-017 SHALL, in SHIFT, present one bit per fall_tick, MSB to LSB, with svalid high for exactly DATA_WIDTH sclk periods; the bit counter is ceil(log2(DATA_WIDTH+1)) bits and never wraps.
REQ-018 SHALL, at the fall_tick after the LSB period, drive svalid=0 and sdata=0 and count gap sclk periods: PKT_GAP if the latched tlast=1, else WORD_GAP; then return to IDLE.
REQ-019 SHALL make changes to s_axis_tdata or s_axis_tlast outside IDLE have no effect on the word in flight.
REQ-020 SHALL guarantee a minimum spacing between consecutive words of WORD_GAP (or PKT_GAP) sclk periods with svalid low, even when tvalid is held high continuously.
REQ-021 SHALL leave sclk, the divider and the outputs unaffected when tvalid is held with tready low.

Reset
REQ-022 SHALL, on areset=1 at a rising aclk edge, set the FSM to IDLE and drive sclk=0, sdata=0, svalid=0, busy=0, s_axis_tready=0, with the divider and counters cleared; s_axis_tready rises in the first cycle after areset deasserts.
REQ-023 SHALL, when reset occurs mid-word, drop that word and resume no partial transmission; svalid is low from the next cycle on.

Configuration
REQ-024 SHALL, with SIMPLE_SERIAL_TX_PARITY_EN defined, insert state PARITY after SHIFT: one extra sclk period with svalid=1 and sdata equal to the XOR of all data bits (even parity).
REQ-025 SHALL, without SIMPLE_SERIAL_TX_PARITY_EN, go from SHIFT directly to GAP with no PARITY state logic present.

Structure
REQ-026 SHALL take the FSM state encoding (typedef) and default DATA_WIDTH, CLK_DIV, WORD_GAP and PKT_GAP constants from shared package simple_serial_pkg.
REQ-027 SHALL implement the sclk divider and fall_tick generation in one sub-module, sclk_gen.

Verification
REQ-028 SHALL cover: CLK_DIV=2, one word 0xA5A50F0F, tlast=0 -> sdata at successive sclk rises 1,0,1,0,0,1,0,1,...,1,1,1,1; svalid high for exactly 32 periods; 2 idle periods follow; then tready=1.
REQ-029 SHALL cover: tvalid held high, words 0x00000001 (tlast=0) then 0x80000000 (tlast=1) -> two 32-bit frames separated by exactly 2 idle periods, followed by 8 idle periods before tready.
REQ-030 SHALL cover: areset pulsed for 1 cycle at bit 10 of a word -> svalid=0, sclk=0, busy=0 the next cycle; no further bits from that word; the next accepted word is sent intact.
REQ-031 SHALL cover: tdata changed to 0xFFFFFFFF during SHIFT of word 0x00000000 -> all 32 transmitted bits are 0.
REQ-032 SHALL cover, with SIMPLE_SERIAL_TX_PARITY_EN defined: word 0x00000007 -> parity bit 1 with svalid high for 33 periods; word 0x00000003 -> parity bit 0.
REQ-033 SHALL cover: a handshake at various sclk phases -> svalid rises at most 2*CLK_DIV+1 aclk cycles after the handshake, always coincident with fall_tick.

Source files
------------

// File: rtl/simple_serial_pkg.sv
// Shared constants, FSM encoding and helpers for the simple serial transmitter.
// ST_PARITY exists only when SIMPLE_SERIAL_TX_PARITY_EN is defined.
package simple_serial_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_CLK_DIV    = 4;
   localparam int unsigned DEF_WORD_GAP   = 2;
   localparam int unsigned DEF_PKT_GAP    = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_GAP    = 3'd3
`ifdef SIMPLE_SERIAL_TX_PARITY_EN
      ,
      ST_PARITY = 3'd4
`endif
   } tx_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/simple_serial_tx_sclk_gen.sv
// Free-running serial clock divider; flags the aclk cycle in which sclk falls.
module sclk_gen
   import simple_serial_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic sclk_o,
   output logic fall_tick_c_o
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic             sclk_q, sclk_d;
   logic             half_c;

   always_comb begin
      half_c        = (div_q == DIV_W'(CLK_DIV - 1));
      div_d         = half_c ? '0 : div_q + DIV_W'(1);
      sclk_d        = half_c ? ~sclk_q : sclk_q;
      fall_tick_c_o = half_c & sclk_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;

endmodule

// File: rtl/simple_serial_tx.sv
// AXI-Stream to MSB-first serial word transmitter with framing strobe and inter-word gaps.
// Define SIMPLE_SERIAL_TX_PARITY_EN to append an even-parity bit after each word.
module simple_serial_tx
   import simple_serial_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
   parameter int unsigned WORD_GAP   = DEF_WORD_GAP,
   parameter int unsigned PKT_GAP    = DEF_PKT_GAP
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic                  sclk,
   output logic                  sdata,
   output logic                  svalid,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int unsigned GAP_W = $clog2(max_u(WORD_GAP, PKT_GAP) + 1);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  last_q, last_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic [GAP_W-1:0]      gap_last_c;
   logic                  sdata_q, sdata_d;
   logic                  svalid_q, svalid_d;
   logic                  tready_q;
   logic                  busy_q;
   logic                  fall_tick_c;
`ifdef SIMPLE_SERIAL_TX_PARITY_EN
   logic                  par_q, par_d;
`endif

   sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk_i         (aclk),
      .rst_i         (areset),
      .sclk_o        (sclk),
      .fall_tick_c_o (fall_tick_c)
   );

   // IDLE is re-entered at the start of the last gap period so a waiting word's MSB lands exactly after it
   assign gap_last_c = (last_q ? GAP_W'(PKT_GAP) : GAP_W'(WORD_GAP)) - GAP_W'(1);

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      sdata_d  = sdata_q;
      svalid_d = svalid_q;
`ifdef SIMPLE_SERIAL_TX_PARITY_EN
      par_d    = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (s_axis_tvalid && tready_q) begin
               data_d  = s_axis_tdata;
               last_d  = s_axis_tlast;
`ifdef SIMPLE_SERIAL_TX_PARITY_EN
               par_d   = ^s_axis_tdata;
`endif
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (fall_tick_c) begin
               sdata_d  = data_q[DATA_WIDTH-1];
               svalid_d = 1'b1;
               data_d   = data_q << 1;
               cnt_d    = CNT_W'(1);
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (fall_tick_c) begin
               if (cnt_q == CNT_W'(DATA_WIDTH)) begin
`ifdef SIMPLE_SERIAL_TX_PARITY_EN
                  sdata_d  = par_q;
                  state_d  = ST_PARITY;
`else
                  sdata_d  = 1'b0;
                  svalid_d = 1'b0;
                  gap_d    = '0;
                  state_d  = ST_GAP;
`endif
               end else begin
                  sdata_d = data_q[DATA_WIDTH-1];
                  data_d  = data_q << 1;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
`ifdef SIMPLE_SERIAL_TX_PARITY_EN
         ST_PARITY: begin
            if (fall_tick_c) begin
               sdata_d  = 1'b0;
               svalid_d = 1'b0;
               gap_d    = '0;
               state_d  = ST_GAP;
            end
         end
`endif
         ST_GAP: begin
            if (gap_q >= gap_last_c) begin
               state_d = ST_IDLE;
            end else if (fall_tick_c) begin
               gap_d = gap_q + GAP_W'(1);
               if (gap_d >= gap_last_c) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         last_q   <= 1'b0;
         cnt_q    <= '0;
         gap_q    <= '0;
         sdata_q  <= 1'b0;
         svalid_q <= 1'b0;
         tready_q <= 1'b0;
         busy_q   <= 1'b0;
`ifdef SIMPLE_SERIAL_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         sdata_q  <= sdata_d;
         svalid_q <= svalid_d;
         tready_q <= (state_d == ST_IDLE);
         busy_q   <= (state_d != ST_IDLE);
`ifdef SIMPLE_SERIAL_TX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   assign s_axis_tready = tready_q;
   assign sdata         = sdata_q;
   assign svalid        = svalid_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_simple_serial_tx.sv
// Bench for simple_serial_tx: edge-indexed timeline model checked every cycle, plus directed literal checks.
module tb_simple_serial_tx;

   localparam int DW = 32;
   localparam int CD = 2;
   localparam int WG = 2;
   localparam int PG = 8;
   localparam int P  = 2 * CD;
`ifdef SIMPLE_SERIAL_TX_PARITY_EN
   localparam int NB = DW + 1;
`else
   localparam int NB = DW;
`endif

   logic          aclk   = 1'b0;
   logic          areset = 1'b1;
   logic [DW-1:0] tdata  = '0;
   logic          tvalid = 1'b0;
   logic          tlast  = 1'b0;
   logic          tready, sclk, sdata, svalid, busy;

   always #5 aclk = ~aclk;

   simple_serial_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD), .WORD_GAP(WG), .PKT_GAP(PG)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .s_axis_tlast  (tlast),
      .sclk          (sclk),
      .sdata         (sdata),
      .svalid        (svalid),
      .busy          (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void expire(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endfunction

   function automatic logic [63:0] frame_of(input logic [DW-1:0] w);
`ifdef SIMPLE_SERIAL_TX_PARITY_EN
      return (64'(w) << 1) | 64'(^w);
`else
      return 64'(w);
`endif
   endfunction

   // Timeline model: m_k counts aclk edges since reset; a word occupies fixed edge windows
   bit            m_ok = 1'b0;
   bit            m_act, m_hs, m_last;
   int            m_k, m_start, m_end, m_idx;
   logic [DW-1:0] m_word;
   logic          e_sclk, e_sdata, e_svalid, e_tready, e_busy;

   always @(posedge aclk) begin
      if (areset) begin
         m_ok  = 1'b1;
         m_k   = 0;
         m_act = 1'b0;
      end else if (m_ok) begin
         m_hs = !m_act && e_tready && tvalid;
         m_k++;
         if (m_hs) begin
            m_act   = 1'b1;
            m_word  = tdata;
            m_last  = tlast;
            m_start = (m_k / P + 1) * P;
            m_end   = m_start + (NB + (m_last ? PG : WG) - 1) * P;
         end
         if (m_act && m_k >= m_end) m_act = 1'b0;
      end
      if (m_ok) begin
         e_sclk   = ((m_k / CD) % 2) == 1;
         e_tready = !m_act && (m_k >= 1);
         e_busy   = m_act;
         e_svalid = 1'b0;
         e_sdata  = 1'b0;
         if (m_act && m_k >= m_start) begin
            m_idx = (m_k - m_start) / P;
            if (m_idx < NB) begin
               e_svalid = 1'b1;
               e_sdata  = (m_idx < DW) ? m_word[DW-1-m_idx] : ^m_word;
            end
         end
      end
   end

   always @(negedge aclk) begin
      if (m_ok) begin
         check("sclk",   64'(sclk),   64'(e_sclk));
         check("svalid", 64'(svalid), 64'(e_svalid));
         check("sdata",  64'(sdata),  64'(e_sdata));
         check("tready", 64'(tready), 64'(e_tready));
         check("busy",   64'(busy),   64'(e_busy));
      end
   end

   // Receiver view: samples at sclk rises, collects frames and svalid-low gaps
   logic        sclk_prev = 1'b0;
   logic [63:0] rx_sr     = '0;
   int          rx_cnt    = 0;
   int          idle_run  = 0;
   bit          have_prev = 1'b0;
   int          gap_last  = -1;
   logic [63:0] last_word = '0;
   int          last_len  = 0;
   int          n_frames  = 0;

   always @(negedge aclk) begin
      if (areset) begin
         rx_sr     = '0;
         rx_cnt    = 0;
         idle_run  = 0;
         have_prev = 1'b0;
      end else if (sclk && !sclk_prev) begin
         if (svalid) begin
            if (rx_cnt == 0 && have_prev) gap_last = idle_run;
            rx_sr = {rx_sr[62:0], sdata};
            rx_cnt++;
         end else begin
            if (rx_cnt > 0) begin
               last_word = rx_sr;
               last_len  = rx_cnt;
               n_frames++;
               rx_sr     = '0;
               rx_cnt    = 0;
               have_prev = 1'b1;
               idle_run  = 0;
            end
            idle_run++;
         end
      end
      sclk_prev = sclk;
   end

   task automatic send(input logic [DW-1:0] w, input logic last, input bit keep, output int lat);
      int t = 0;
      tdata  = w;
      tlast  = last;
      tvalid = 1'b1;
      while (!tready && t < 2000) begin
         @(negedge aclk);
         t++;
      end
      if (!tready) begin
         expire("send_handshake");
         lat = -1;
         return;
      end
      @(negedge aclk);
      if (!keep) tvalid = 1'b0;
      lat = 0;
      while (!svalid && lat < 100) begin
         @(negedge aclk);
         lat++;
      end
      check("latency_bound", 64'(lat >= 1 && lat <= 2 * CD + 1), 64'(1));
      check("svalid_rise_on_fall", 64'(sclk), 64'(0));
   endtask

   task automatic wait_end(output int cnt);
      int t = 0;
      while (svalid && t < 1000) begin
         @(negedge aclk);
         t++;
      end
      if (svalid) begin
         expire("svalid_fall");
         cnt = -1;
         return;
      end
      cnt = 0;
      while (!tready && cnt < 1000) begin
         @(negedge aclk);
         cnt++;
      end
      if (!tready) expire("tready_return");
      repeat (2) @(negedge aclk);
   endtask

   logic [DW-1:0] ph_words [4] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0F0F_F0F0};

   initial begin
      int lat, cnt, frames_before, t;

      repeat (3) @(negedge aclk);
      check("rst_sclk",   64'(sclk),   64'(0));
      check("rst_svalid", 64'(svalid), 64'(0));
      check("rst_busy",   64'(busy),   64'(0));
      check("rst_tready", 64'(tready), 64'(0));
      areset = 1'b0;
      @(negedge aclk);
      check("tready_after_rst", 64'(tready), 64'(1));

      // Single word, no tlast
      send(32'hA5A5_0F0F, 1'b0, 1'b0, lat);
      wait_end(cnt);
      check("a_word", last_word, frame_of(32'hA5A5_0F0F));
      check("a_len", 64'(last_len), 64'(NB));
      check("a_gap_to_tready", 64'(cnt), 64'((WG - 1) * P));

      // Back-to-back words with tvalid held high
      send(32'h0000_0001, 1'b0, 1'b1, lat);
      send(32'h8000_0000, 1'b1, 1'b0, lat);
      check("b_word0", last_word, frame_of(32'h0000_0001));
      wait_end(cnt);
      check("b_word1", last_word, frame_of(32'h8000_0000));
      check("b_word_gap", 64'(gap_last), 64'(WG));
      check("b_pkt_gap_to_tready", 64'(cnt), 64'((PG - 1) * P));

      // Input changes during SHIFT must not reach the wire
      send(32'h0000_0000, 1'b0, 1'b0, lat);
      tdata = 32'hFFFF_FFFF;
      tlast = 1'b1;
      wait_end(cnt);
      check("c_word", last_word, frame_of(32'h0000_0000));
      check("c_gap_uses_latched_last", 64'(cnt), 64'((WG - 1) * P));

      // Reset mid-word
      send(32'h1234_5678, 1'b0, 1'b0, lat);
      t = 0;
      while (rx_cnt < 10 && t < 1000) begin
         @(negedge aclk);
         t++;
      end
      if (rx_cnt < 10) expire("d_bit10");
      frames_before = n_frames;
      areset = 1'b1;
      @(negedge aclk);
      check("d_rst_svalid", 64'(svalid), 64'(0));
      check("d_rst_sclk",   64'(sclk),   64'(0));
      check("d_rst_busy",   64'(busy),   64'(0));
      areset = 1'b0;
      send(32'hCAFE_F00D, 1'b1, 1'b0, lat);
      wait_end(cnt);
      check("d_frames", 64'(n_frames), 64'(frames_before + 1));
      check("d_word", last_word, frame_of(32'hCAFE_F00D));
      check("d_len", 64'(last_len), 64'(NB));

`ifdef SIMPLE_SERIAL_TX_PARITY_EN
      send(32'h0000_0007, 1'b0, 1'b0, lat);
      wait_end(cnt);
      check("p7_len", 64'(last_len), 64'(33));
      check("p7_word", last_word, 64'h0000_0000_0000_000F);
      send(32'h0000_0003, 1'b0, 1'b0, lat);
      wait_end(cnt);
      check("p3_word", last_word, 64'h0000_0000_0000_0006);
`endif

      // Handshakes at different sclk phases
      for (int ph = 0; ph < 4; ph++) begin
         repeat (ph) @(negedge aclk);
         send(ph_words[ph], ph[0], 1'b0, lat);
         wait_end(cnt);
         check("ph_word", last_word, frame_of(ph_words[ph]));
         check("ph_gap_to_tready", 64'(cnt), 64'(((ph[0] ? PG : WG) - 1) * P));
      end

      repeat (4) @(negedge aclk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
